// File: rtl/pixel_plane_collect.sv
// pixel_plane_collect: receive side of the bit-plane serial link.
// Collects NPLANE consecutive plane words into a parallel register bank and flags completion.
`ifndef CACHE_WIDTH
`define CACHE_WIDTH 32
`endif

`default_nettype none

module pixel_plane_collect #(
  parameter int DW     = `CACHE_WIDTH,
  parameter int NPLANE = 19
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        din_vld,
  input  logic [DW-1:0]               din,
  output logic [NPLANE*DW-1:0]        planes,
  output logic                        oe,
  output logic                        err,
  output logic                        busy,
  output logic [$clog2(NPLANE)-1:0]   plane_idx
);

  localparam int            CW   = $clog2(NPLANE);
  localparam logic [CW-1:0] LAST = CW'(NPLANE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_nxt;
  logic                      shadow_we;
  logic                      load_planes;
  logic                      oe_nxt;
  logic                      err_nxt;
  logic [DW-1:0]             shadow [NPLANE-1];
  logic [(NPLANE-1)*DW-1:0]  shadow_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      oe    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      oe    <= oe_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shadow_we   = 1'b0;
    load_planes = 1'b0;
    oe_nxt      = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (din_vld) begin
          shadow_we = 1'b1;
          cnt_nxt   = CW'(1);
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (din_vld) begin
          if (cnt == LAST) begin
            // Final word bypasses the shadow bank and lands directly in planes.
            load_planes = 1'b1;
            oe_nxt      = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end else begin
            shadow_we = 1'b1;
            cnt_nxt   = cnt + CW'(1);
          end
        end else begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPLANE - 1; k++) begin
        shadow[k] <= '0;
      end
    end else if (shadow_we) begin
      for (int k = 0; k < NPLANE - 1; k++) begin
        if (cnt == CW'(k)) begin
          shadow[k] <= din;
        end
      end
    end
  end

  for (genvar k = 0; k < NPLANE - 1; k++) begin : g_flat
    assign shadow_flat[k*DW +: DW] = shadow[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      planes <= '0;
    end else if (load_planes) begin
      planes <= {din, shadow_flat};
    end
  end

  assign busy      = (state == RECV);
  assign plane_idx = cnt;

endmodule

`default_nettype wire

// File: tb/tb_pixel_plane_collect.sv
// tb_pixel_plane_collect: directed self-checking bench for pixel_plane_collect.
// Inputs change on the falling edge; outputs are sampled on the falling edge before new drive.
`default_nettype none

module tb_pixel_plane_collect;

  localparam int DW     = 32;
  localparam int NPLANE = 19;
  localparam int CW     = $clog2(NPLANE);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  din_vld = 1'b0;
  logic [DW-1:0]         din = '0;
  logic [NPLANE*DW-1:0]  planes;
  logic                  oe;
  logic                  err;
  logic                  busy;
  logic [CW-1:0]         plane_idx;

  int tests = 0;
  int fails = 0;
  int oe_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  logic [DW-1:0] burst_w [NPLANE];
  logic [DW-1:0] exp_planes [NPLANE];

  pixel_plane_collect #(.DW(DW), .NPLANE(NPLANE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_vld   (din_vld),
    .din       (din),
    .planes    (planes),
    .oe        (oe),
    .err       (err),
    .busy      (busy),
    .plane_idx (plane_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (oe === 1'b1) oe_cnt++;
    if (err === 1'b1) err_cnt++;
    if (oe === 1'b1 && err === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_planes(input string tag);
    for (int k = 0; k < NPLANE; k++) begin
      check(tag, 64'(planes[k*DW +: DW]), 64'(exp_planes[k]));
    end
  endtask

  // Called on the oe cycle of a burst held in burst_w.
  task automatic verify_done(input string tag);
    check({tag, "_oe"}, 64'(oe), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_idx"}, 64'(plane_idx), 64'd0);
    for (int k = 0; k < NPLANE; k++) exp_planes[k] = burst_w[k];
    check_planes({tag, "_planes"});
  endtask

  task automatic run_burst(input string tag, input logic [DW-1:0] base, input bit rnd,
                           input bit chk_prev);
    logic [DW-1:0] w;
    for (int k = 0; k < NPLANE; k++) begin
      @(negedge clk);
      if (k == 0 && chk_prev) begin
        verify_done({tag, "_prev"});
      end else if (k > 0) begin
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_idx"}, 64'(plane_idx), 64'(k));
        check({tag, "_nooe"}, 64'(oe), 64'd0);
      end
      w = rnd ? DW'($urandom) : base + DW'(k);
      burst_w[k] = w;
      din_vld = 1'b1;
      din = w;
    end
  endtask

  task automatic finish_burst(input string tag);
    @(negedge clk);
    verify_done(tag);
    din_vld = 1'b0;
    din = DW'($urandom);
    @(negedge clk);
    check({tag, "_oe_width"}, 64'(oe), 64'd0);
    check({tag, "_hold"}, 64'(planes[0 +: DW]), 64'(exp_planes[0]));
  endtask

  initial begin
    for (int k = 0; k < NPLANE; k++) exp_planes[k] = '0;

    // Reset state
    #12;
    check("rst_oe", 64'(oe), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_idx", 64'(plane_idx), 64'd0);
    check_planes("rst_planes");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single burst
    run_burst("single", 32'h100, 1'b0, 1'b0);
    finish_burst("single");

    // Back-to-back bursts
    run_burst("b2b_a", 32'hA00, 1'b0, 1'b0);
    run_burst("b2b_b", 32'hB00, 1'b0, 1'b1);
    finish_burst("b2b_b");

    // Early drop after 7 words
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      din_vld = 1'b1;
      din = 32'hE00 + 32'(k);
    end
    @(negedge clk);
    check("drop_busy", 64'(busy), 64'd1);
    check("drop_idx", 64'(plane_idx), 64'd7);
    din_vld = 1'b0;
    @(negedge clk);
    check("drop_err", 64'(err), 64'd1);
    check("drop_oe", 64'(oe), 64'd0);
    check("drop_busy_after", 64'(busy), 64'd0);
    check("drop_idx_after", 64'(plane_idx), 64'd0);
    @(negedge clk);
    check("drop_err_width", 64'(err), 64'd0);
    check_planes("drop_planes");

    // Reset mid-burst
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      din_vld = 1'b1;
      din = 32'h900 + 32'(k);
    end
    @(negedge clk);
    rst_n = 1'b0;
    din_vld = 1'b0;
    #1;
    for (int k = 0; k < NPLANE; k++) exp_planes[k] = '0;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_idx", 64'(plane_idx), 64'd0);
    check("mrst_oe", 64'(oe), 64'd0);
    check("mrst_err", 64'(err), 64'd0);
    check_planes("mrst_planes");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_post_oe", 64'(oe), 64'd0);
    check("mrst_post_err", 64'(err), 64'd0);
    run_burst("mrst_full", 32'hC00, 1'b0, 1'b0);
    finish_burst("mrst_full");

    // Idle gap with din noise
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("gap_oe", 64'(oe), 64'd0);
      check("gap_err", 64'(err), 64'd0);
      check("gap_busy", 64'(busy), 64'd0);
      din_vld = 1'b0;
      din = DW'($urandom);
    end
    run_burst("gap_burst", 32'hD00, 1'b0, 1'b0);
    finish_burst("gap_burst");

    // Random bursts chained back-to-back
    for (int i = 0; i < 100; i++) begin
      run_burst("rnd", '0, 1'b1, (i > 0));
    end
    finish_burst("rnd");

    check("total_oe", 64'(oe_cnt), 64'd105);
    check("total_err", 64'(err_cnt), 64'd1);
    check("oe_err_overlap", 64'(both_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_plane_collect.md
Name: pixel_plane_collect

Overview:
- Receive side of the bit-plane serial link: accepts a contiguous burst of NPLANE bit-plane words, one per clock, plane 0 first, qualified by a valid strobe.
- Reassembles the burst into NPLANE parallel plane registers and presents them together with a one-cycle done strobe.
- Sits downstream of the pixel plane serializer in the pixel_processor path; feeds bit-plane consumers (plane cache write-back, checker logic).

Parameters:
DW, `CACHE_WIDTH, width of one bit-plane word
NPLANE, 19, number of planes per burst; minimum 2; plane index counter width = clog2(NPLANE)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset, applied on negedge rst_n
din_vld  input  1  word valid; high for NPLANE consecutive cycles per burst
din  input  DW  plane word; plane 0 on the first valid cycle of a burst
planes  output  NPLANE*DW  assembled planes; plane k at bits [k*DW +: DW]; registered
oe  output  1  one-cycle pulse: planes updated with a complete burst
err  output  1  one-cycle pulse: burst aborted (din_vld dropped early)
busy  output  1  high while a burst is partially received (state RECV)
plane_idx  output  clog2(NPLANE)  index of the next expected plane; 0 in IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE, cnt=0, shadow regs=0, planes=0, oe=0, err=0, busy=0, plane_idx=0. Reset mid-burst discards the partial burst. planes are not updated and no oe or err pulse is issued.
- States: IDLE, RECV. busy=1 exactly when state==RECV. plane_idx=cnt.
- IDLE: din_vld=1 -> shadow[0]<=din, cnt<=1, go to RECV. din_vld=0 -> stay in IDLE, nothing changes.
- RECV, din_vld=1, cnt<NPLANE-1: shadow[cnt]<=din, cnt<=cnt+1.
- RECV, din_vld=1, cnt==NPLANE-1 (last word): on the same edge, planes<={din, shadow[NPLANE-2:0]}, oe<=1, cnt<=0, go to IDLE.
- Latency: oe is high in the cycle after the last word is sampled. planes is valid in that same cycle and holds until the next complete burst.
- Back-to-back bursts: if din_vld stays high after the last word, the next word is plane 0 of a new burst. IDLE then sees din_vld=1 in the oe cycle and captures it. No dead cycle is required between bursts.
- Early drop: in RECV with din_vld=0 and cnt in 1..NPLANE-1, err<=1 for one cycle, cnt<=0, go to IDLE. planes keeps its previous contents. Shadow contents are don't-care.
- Shadow registers stage the burst, so planes never shows a mix of two bursts.
- oe and err are never high in the same cycle. Each pulse is exactly one cycle wide.
- No backpressure: the consumer must take planes before the next oe. The next complete burst overwrites planes with no overflow flag.
- din is ignored whenever din_vld=0.

Test Plan:
- Single burst: din_vld high 19 cycles, din=k+0x100 on plane k -> exactly one oe pulse, in the cycle after the 19th word; planes[k]=0x100+k for all k; busy high for 18 cycles; err never asserted.
- Back-to-back: din_vld held high 38 cycles, burst A = 0xA00+k, burst B = 0xB00+k -> two oe pulses 19 cycles apart; planes=A after the first pulse and =B after the second, with no mixed words.
- Early drop: din_vld high 7 cycles then low -> err pulse one cycle after the drop, no oe, planes unchanged from the previous burst, busy low and plane_idx=0 after the err cycle.
- Reset mid-burst: rst_n low after 10 words, then a full burst of 0xC00+k -> outputs all 0 during reset, no oe/err from the partial burst; a single oe with planes[k]=0xC00+k after the full burst.
- Idle gaps and din noise: din_vld=0 for 50 cycles while din toggles randomly, then one burst -> no pulses during the gap; planes match the burst only.
- Pairing with the serializer: drive from pixel_convert_sel with random din_b0..b18 -> planes[k]==din_bk for 100 random bursts.
